// File: rtl/fb_arbiter_pkg.sv
// Shared types and defaults for the framebuffer arbiter: owner encoding,
// pipeline tag layout and the default starvation limit.
package fb_arbiter_pkg;

    localparam int unsigned STARVE_LIM_DEFAULT = 8;

    typedef enum logic {
        OWNER_DISP = 1'b0,
        OWNER_CPU  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_read;
    } pipe_tag_t;

    localparam pipe_tag_t PIPE_IDLE = '{valid: 1'b0, owner: OWNER_DISP, is_read: 1'b0};

    // True when a tag leaving the pipeline carries read data for requester o.
    function automatic logic tag_returns(input pipe_tag_t t, input owner_e o);
        return t.valid && t.is_read && (t.owner == o);
    endfunction

endpackage

// File: rtl/fb_arb_starve_ctr.sv
// Saturating CPU starvation counter; expired flags that the CPU has waited
// STARVE_LIM consecutive cycles. Only instantiated under FB_ARB_STARVE_EN.
module fb_arb_starve_ctr
    import fb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    logic [7:0] count;

    // NOTE: clocked state is written with <= so every register samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (waiting && (count != LIM)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIM);

endmodule

// File: rtl/fb_arbiter.sv
// Two-requester framebuffer arbiter (display fetch vs CPU) with a two-stage
// owner pipeline; define FB_ARB_STARVE_EN to add the forced CPU slot.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              vga_hold
);

    // Range is validated in both builds so flipping the macro never
    // exposes a bad value late.
    if (STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_lim_check
        $error("fb_arbiter: STARVE_LIM must be in 1..255");
    end

    logic      forced;
    pipe_tag_t grant_tag;
    pipe_tag_t stage1;
    pipe_tag_t stage2;

`ifdef FB_ARB_STARVE_EN
    logic cpu_expired;

    fb_arb_starve_ctr #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve_ctr (
        .clk     (clk),
        .reset   (reset),
        .waiting (cpu_req & ~cpu_gnt),
        .clear   (cpu_gnt | ~cpu_req),
        .expired (cpu_expired)
    );

    assign forced = cpu_expired & cpu_req & ~reset;
`else
    assign forced = 1'b0;
`endif

    assign vga_hold = forced;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else leaves a value held, which would infer a latch.
    always_comb begin
        disp_gnt  = 1'b0;
        cpu_gnt   = 1'b0;
        grant_tag = PIPE_IDLE;
        if (!reset) begin
            if (forced) begin
                cpu_gnt = 1'b1;
            end else if (disp_req) begin
                disp_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
        if (disp_gnt) begin
            grant_tag = '{valid: 1'b1, owner: OWNER_DISP, is_read: 1'b1};
        end else if (cpu_gnt) begin
            grant_tag = '{valid: 1'b1, owner: OWNER_CPU, is_read: ~cpu_we};
        end
    end

    // Stage1 lines up with the registered address, stage2 with mem_rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1 <= PIPE_IDLE;
            stage2 <= PIPE_IDLE;
        end else begin
            stage1 <= grant_tag;
            stage2 <= stage1;
        end
    end

    // Address and write data hold across idle cycles; only mem_we drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= cpu_gnt & cpu_we;
            if (disp_gnt) begin
                mem_addr <= disp_addr;
            end else if (cpu_gnt) begin
                mem_addr <= cpu_addr;
                if (cpu_we) begin
                    mem_wdata <= cpu_wdata;
                end
            end
        end
    end

    assign disp_rvalid = tag_returns(stage2, OWNER_DISP);
    assign cpu_rvalid  = tag_returns(stage2, OWNER_CPU);
    assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed table-driven bench for fb_arbiter plus hand-written sequences for
// starvation (or absolute priority without FB_ARB_STARVE_EN) and reset.
module tb_fb_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          vga_hold;

    int checks = 0;
    int errors = 0;

    fb_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_LIM (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .vga_hold    (vga_hold)
    );

    always #5 clk = ~clk;

    // Memory model: data for an address appears the cycle after it is presented.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 18'h00010) return 16'hBEEF;
        return a[15:0] ^ 16'h5A00;
    endfunction

    always @(posedge clk) mem_rdata <= mem_fn(mem_addr);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          dreq;
        logic [AW-1:0] daddr;
        logic          creq;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwdata;
        logic          e_dgnt;
        logic          e_cgnt;
        logic [AW-1:0] e_maddr;
        logic          e_mwe;
        logic [DW-1:0] e_mwdata;
        logic          e_drv;
        logic          e_crv;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic dreq, input logic [AW-1:0] daddr, input logic creq,
                     input logic cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwdata,
                     input logic e_dgnt, input logic e_cgnt, input logic [AW-1:0] e_maddr,
                     input logic e_mwe, input logic [DW-1:0] e_mwdata, input logic e_drv,
                     input logic e_crv, input logic [DW-1:0] e_rdata);
        vq.push_back('{dreq, daddr, creq, cwe, caddr, cwdata, e_dgnt, e_cgnt,
                       e_maddr, e_mwe, e_mwdata, e_drv, e_crv, e_rdata});
    endtask

    task automatic drive_idle();
        disp_req  = 1'b0;
        disp_addr = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_disp_gnt"}, 32'(disp_gnt), 0);
        check({tag, "_cpu_gnt"}, 32'(cpu_gnt), 0);
        check({tag, "_vga_hold"}, 32'(vga_hold), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_disp_rvalid"}, 32'(disp_rvalid), 0);
        check({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
        check({tag, "_disp_rdata"}, 32'(disp_rdata), 0);
        check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
    endtask

    initial begin
        int hold_bad;
        int disp_cnt;

        //   dreq daddr     creq we caddr     wdata      dg cg maddr     we wdata      drv crv rdata
        v(0, 18'h0,     0, 0, 18'h0,     16'h0,     0, 0, 18'h0,     0, 16'h0,     0, 0, 16'h0);
        v(0, 18'h0,     1, 0, 18'h10,    16'h0,     0, 1, 18'h0,     0, 16'h0,     0, 0, 16'h0);
        v(0, 18'h0,     0, 0, 18'h0,     16'h0,     0, 0, 18'h10,    0, 16'h0,     0, 0, 16'h0);
        v(0, 18'h0,     0, 0, 18'h0,     16'h0,     0, 0, 18'h10,    0, 16'h0,     0, 1, 16'hBEEF);
        v(1, 18'h100,   1, 0, 18'h20,    16'h0,     1, 0, 18'h10,    0, 16'h0,     0, 0, 16'h0);
        v(0, 18'h0,     1, 0, 18'h20,    16'h0,     0, 1, 18'h100,   0, 16'h0,     0, 0, 16'h0);
        v(1, 18'h1,     0, 0, 18'h0,     16'h0,     1, 0, 18'h20,    0, 16'h0,     1, 0, 16'h5B00);
        v(0, 18'h0,     1, 0, 18'h2,     16'h0,     0, 1, 18'h1,     0, 16'h0,     0, 1, 16'h5A20);
        v(1, 18'h3,     0, 0, 18'h0,     16'h0,     1, 0, 18'h2,     0, 16'h0,     1, 0, 16'h5A01);
        v(0, 18'h0,     1, 0, 18'h4,     16'h0,     0, 1, 18'h3,     0, 16'h0,     0, 1, 16'h5A02);
        v(0, 18'h0,     1, 1, 18'h30,    16'h1234,  0, 1, 18'h4,     0, 16'h0,     1, 0, 16'h5A03);
        v(0, 18'h0,     0, 0, 18'h0,     16'h0,     0, 0, 18'h30,    1, 16'h1234,  0, 1, 16'h5A04);
        v(0, 18'h0,     0, 0, 18'h0,     16'h0,     0, 0, 18'h30,    0, 16'h1234,  0, 0, 16'h0);
        v(0, 18'h0,     1, 1, 18'h3FFFF, 16'hFFFF,  0, 1, 18'h30,    0, 16'h1234,  0, 0, 16'h0);
        v(0, 18'h0,     0, 0, 18'h0,     16'h0,     0, 0, 18'h3FFFF, 1, 16'hFFFF,  0, 0, 16'h0);
        v(1, 18'h3FFFF, 0, 0, 18'h0,     16'h0,     1, 0, 18'h3FFFF, 0, 16'hFFFF,  0, 0, 16'h0);
        v(0, 18'h0,     0, 0, 18'h0,     16'h0,     0, 0, 18'h3FFFF, 0, 16'hFFFF,  0, 0, 16'h0);
        v(0, 18'h0,     0, 0, 18'h0,     16'h0,     0, 0, 18'h3FFFF, 0, 16'hFFFF,  1, 0, 16'hA5FF);

        // Reset: outputs low even with both requests asserted.
        reset = 1'b1;
        drive_idle();
        disp_req = 1'b1;
        cpu_req  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            disp_req  = vq[i].dreq;
            disp_addr = vq[i].daddr;
            cpu_req   = vq[i].creq;
            cpu_we    = vq[i].cwe;
            cpu_addr  = vq[i].caddr;
            cpu_wdata = vq[i].cwdata;
            @(negedge clk);
            check($sformatf("v%0d_disp_gnt", i), 32'(disp_gnt), 32'(vq[i].e_dgnt));
            check($sformatf("v%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vq[i].e_cgnt));
            check($sformatf("v%0d_vga_hold", i), 32'(vga_hold), 0);
            check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vq[i].e_maddr));
            check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vq[i].e_mwe));
            check($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vq[i].e_mwdata));
            check($sformatf("v%0d_disp_rvalid", i), 32'(disp_rvalid), 32'(vq[i].e_drv));
            check($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vq[i].e_crv));
            check($sformatf("v%0d_disp_rdata", i), 32'(disp_rdata),
                  vq[i].e_drv ? 32'(vq[i].e_rdata) : 32'h0);
            check($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata),
                  vq[i].e_crv ? 32'(vq[i].e_rdata) : 32'h0);
        end

`ifdef FB_ARB_STARVE_EN
        // Display saturates the bus; pending CPU write is forced on wait cycle 9.
        for (int w = 1; w <= 9; w++) begin
            @(posedge clk);
            #1;
            disp_req  = 1'b1;
            disp_addr = 18'h200;
            cpu_req   = 1'b1;
            cpu_we    = 1'b1;
            cpu_addr  = 18'h123;
            cpu_wdata = 16'hCAFE;
            @(negedge clk);
            check($sformatf("starve1_w%0d_cpu_gnt", w), 32'(cpu_gnt), (w == 9) ? 32'd1 : 32'd0);
            check($sformatf("starve1_w%0d_vga_hold", w), 32'(vga_hold), (w == 9) ? 32'd1 : 32'd0);
            check($sformatf("starve1_w%0d_disp_gnt", w), 32'(disp_gnt), (w == 9) ? 32'd0 : 32'd1);
        end
        // New CPU read issued immediately: counter must restart from zero.
        for (int w = 1; w <= 9; w++) begin
            @(posedge clk);
            #1;
            cpu_we   = 1'b0;
            cpu_addr = 18'h124;
            @(negedge clk);
            if (w == 1) begin
                check("starve_write_mem_we", 32'(mem_we), 1);
                check("starve_write_mem_addr", 32'(mem_addr), 32'h123);
                check("starve_write_mem_wdata", 32'(mem_wdata), 32'hCAFE);
            end
            check($sformatf("starve2_w%0d_cpu_gnt", w), 32'(cpu_gnt), (w == 9) ? 32'd1 : 32'd0);
            check($sformatf("starve2_w%0d_vga_hold", w), 32'(vga_hold), (w == 9) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        check("starve_read_mem_addr", 32'(mem_addr), 32'h124);
        check("starve_read_mem_we", 32'(mem_we), 0);
        check("starve_after_vga_hold", 32'(vga_hold), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("starve_read_cpu_rvalid", 32'(cpu_rvalid), 1);
        check("starve_read_cpu_rdata", 32'(cpu_rdata), 32'h5B24);
`else
        // Absolute display priority: CPU never granted while display requests.
        hold_bad = 0;
        disp_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            disp_req  = 1'b1;
            disp_addr = 18'h200;
            cpu_req   = 1'b1;
            cpu_we    = 1'b0;
            cpu_addr  = 18'h124;
            @(negedge clk);
            if (cpu_gnt !== 1'b0 || vga_hold !== 1'b0) hold_bad++;
            if (disp_gnt === 1'b1) disp_cnt++;
        end
        check("prio_cpu_gnt_or_vga_hold_cycles", 32'(hold_bad), 0);
        check("prio_disp_gnt_cycles", 32'(disp_cnt), 300);
        @(posedge clk);
        #1;
        disp_req = 1'b0;
        @(negedge clk);
        check("prio_cpu_gnt_after_disp_drop", 32'(cpu_gnt), 1);
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
`endif

        repeat (3) @(posedge clk);

        // Reset the cycle after a display grant: that read must never return.
        #1;
        disp_req  = 1'b1;
        disp_addr = 18'h55;
        @(negedge clk);
        check("rst_seq_disp_gnt", 32'(disp_gnt), 1);
        @(posedge clk);
        #1;
        disp_req = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_all_zero("rst_seq_during");
        @(posedge clk);
        #1;
        reset     = 1'b0;
        disp_req  = 1'b1;
        disp_addr = 18'h7;
        @(negedge clk);
        check("rst_seq_first_grant", 32'(disp_gnt), 1);
        check("rst_seq_no_stale_rvalid0", 32'(disp_rvalid), 0);
        @(posedge clk);
        #1;
        disp_req = 1'b0;
        @(negedge clk);
        check("rst_seq_no_stale_rvalid1", 32'(disp_rvalid), 0);
        check("rst_seq_mem_addr", 32'(mem_addr), 32'h7);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_seq_new_rvalid", 32'(disp_rvalid), 1);
        check("rst_seq_new_rdata", 32'(disp_rdata), 32'h5A07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
